lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store unit sitting directly downstream of the decode-stage control logic, in the memory stage. Consumes the 3-bit `addr_mode` access code plus the ALU-computed address and store data. Drives a word-wide request/acknowledge data bus with byte enables, and formats returned load data (byte/half/word, signed/unsigned). Holds the pipeline with `stall` while a bus transaction is outstanding.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: address and data width; only 32 is supported.
- `TIMEOUT_CYCLES`, default 16: bus-wait limit in cycles; used only with `LSU_TIMEOUT_EN`.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_rd`  in  1  load request this cycle.
- `mem_wr`  in  1  store request this cycle.
- `addr_mode`  in  3  access code: 000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW.
- `addr`  in  32  byte address from the ALU.
- `wdata`  in  32  store data (rs2).
- `bus_req`  out  1  bus request; registered.
- `bus_we`  out  1  1 = write.
- `bus_addr`  out  32  word-aligned address, `{addr[31:2],2'b00}`.
- `bus_be`  out  4  byte enables.
- `bus_wdata`  out  32  lane-replicated store data.
- `bus_ack`  in  1  bus completion, single-cycle pulse.
- `bus_rdata`  in  32  read word; valid when `bus_ack` is 1.
- `rd_data`  out  32  formatted load result; valid when `done` is 1.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle error pulse, coincident with `done`.
- `stall`  out  1  hold upstream pipeline stages.

## Operation
- **States**
  - IDLE (reset).
  - BUSY (request outstanding).
  - DONE (result presented).
- **IDLE**
  - The unit accepts a request when exactly one of `mem_rd`/`mem_wr` is 1.
  - It latches `addr_mode`, `addr` and `wdata`.
  - Legal request: go to BUSY.
  - Misaligned request: go to DONE with error set. Misaligned means halfword with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - Both `mem_rd` and `mem_wr` = 1: treated as illegal; go to DONE with error set and issue no bus transaction.
  - A load code with `mem_wr`, or a store code with `mem_rd`, is illegal and handled the same way.
- **BUSY**
  - `bus_req`=1. `bus_we`, `bus_addr`, `bus_be` and `bus_wdata` are held stable until ack.
  - On `bus_ack`=1: capture the formatted load data (or 0 for stores), then go to DONE.
- **DONE**
  - `done`=1, with `err` per the captured error flag. Then go to IDLE.
- **Load formatting** (lane = `addr[1:0]`)
  - LB/LBU: byte `bus_rdata[8*lane+:8]`, sign- or zero-extended.
  - LH/LHU: half `bus_rdata[16*addr[1]+:16]`, sign- or zero-extended.
  - LW: full word.
- **Store formatting**
  - SB: `bus_wdata={4{wdata[7:0]}}`, `bus_be=4'b0001<<lane`.
  - SH: `bus_wdata={2{wdata[15:0]}}`, `bus_be=4'b0011<<lane`.
  - SW: `bus_wdata=wdata`, `bus_be=4'hF`.
  - For loads, `bus_be=4'hF`.
- **`stall`** is combinational: 1 when (IDLE and a request is present) or in BUSY; 0 in DONE. The pipeline advances on the DONE cycle and consumes `rd_data` there.
- **Ignored acks:** `bus_ack` while not in BUSY is ignored.
- **Error results:** `rd_data`=0 on every error completion.

## Timing
- **Reset values:** state IDLE; `bus_req`, `bus_we`, `done`, `err` = 0; `bus_addr`, `bus_be`, `bus_wdata`, `rd_data` = 0. `stall` follows its combinational definition.
- **Cycle sequence:** request sampled at cycle N → `bus_req` high from N+1 → ack at cycle M (≥N+1) → `done`/`rd_data` at M+1 → IDLE at M+2.
- **Minimum latency:** 2 cycles, request to `done`.
- **Zero-wait ack:** an ack in the first BUSY cycle is legal.
- **Back-to-back:** a new request may be presented in the cycle after DONE.
- **Errors:** a misaligned or illegal request produces `done`=`err`=1 at N+1, with no `bus_req`.
- **Reset mid-transaction:** return to IDLE and drop `bus_req` at that edge. A later `bus_ack` is ignored.

## Configuration
- Macro: `LSU_TIMEOUT_EN`.
- **Defined:**
  - A counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When it reaches `TIMEOUT_CYCLES`, the unit drops `bus_req`, goes to DONE with `err`=1 and `rd_data`=0.
  - An ack in the same cycle as the timeout wins, giving a normal completion.
- **Undefined:** no counter; BUSY waits indefinitely and `TIMEOUT_CYCLES` is unused.

## Test plan
- **LB:** `addr`=0x1003, `addr_mode`=000, `bus_rdata`=0x80FF_1234, ack after 2 wait cycles → `bus_addr`=0x1000, `rd_data`=0xFFFF_FF80, `done` exactly 4 cycles after request.
- **LHU:** `addr`=0x2002, `bus_rdata`=0xBEEF_0000, zero-wait ack → `rd_data`=0x0000_BEEF, `stall` high exactly 2 cycles.
- **SH:** `addr`=0x3002, `wdata`=0x1234_ABCD → `bus_we`=1, `bus_be`=4'b1100, `bus_wdata`=0xABCD_ABCD, held stable until ack.
- **Misaligned LW:** `addr`=0x4001 → no `bus_req`; `done`=`err`=1 next cycle; `rd_data`=0.
- **Reset in BUSY:** `rst` pulsed during BUSY → `bus_req`=0 next cycle, state IDLE, a subsequent stray `bus_ack` produces no `done`.
- **With `LSU_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4:** no ack → `bus_req` drops after 4 BUSY cycles, then `done`=`err`=1.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Memory-stage load/store controller: request/ack bus master with byte lanes and load formatting.
// Optional bus-wait watchdog enabled by defining LSU_TIMEOUT_EN.
module lsu_ctrl #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_rd,
  input  logic                  mem_wr,
  input  logic [2:0]            addr_mode,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [DATA_WIDTH-1:0] bus_addr,
  output logic [3:0]            bus_be,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_ack,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  done,
  output logic                  err,
  output logic                  stall
);

  if (DATA_WIDTH != 32 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("lsu_ctrl: DATA_WIDTH must be 32 and TIMEOUT_CYCLES nonzero");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state_q, state_d;
  logic [2:0]            mode_q, mode_d;
  logic [1:0]            lane_q, lane_d;
  logic                  bus_req_d, bus_we_d, done_d, err_d;
  logic [DATA_WIDTH-1:0] bus_addr_d, bus_wdata_d, rd_data_d;
  logic [3:0]            bus_be_d;
  logic                  req_any, is_store, misaligned, illegal, tmo_hit;
  logic [3:0]            st_be;
  logic [DATA_WIDTH-1:0] st_wdata;

  // Extract and extend the addressed byte/half from the returned word.
  function automatic logic [31:0] fmt_load(input logic [2:0] mode, input logic [1:0] lane,
                                           input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (mode)
      3'b000:  fmt_load = {{24{b[7]}}, b};
      3'b001:  fmt_load = {{16{h[15]}}, h};
      3'b011:  fmt_load = {24'h000000, b};
      3'b100:  fmt_load = {16'h0000, h};
      default: fmt_load = word;
    endcase
  endfunction

  assign req_any  = mem_rd | mem_wr;
  assign is_store = addr_mode[2] & (addr_mode[1] | addr_mode[0]);
  assign illegal  = (mem_rd & mem_wr) | (mem_wr & ~is_store) | (mem_rd & is_store);

  // Alignment check and store lane steering from the incoming access code.
  always_comb begin
    misaligned = 1'b0;
    st_be      = 4'hF;
    st_wdata   = '0;
    case (addr_mode)
      3'b001, 3'b100: misaligned = addr[0];
      3'b010:         misaligned = |addr[1:0];
      3'b101: begin
        st_be    = 4'(4'b0001 << addr[1:0]);
        st_wdata = {4{wdata[7:0]}};
      end
      3'b110: begin
        misaligned = addr[0];
        st_be      = 4'(4'b0011 << addr[1:0]);
        st_wdata   = {2{wdata[15:0]}};
      end
      3'b111: begin
        misaligned = |addr[1:0];
        st_wdata   = wdata;
      end
      default: ;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_q;

  // Counts ack-less BUSY cycles; idles at zero outside BUSY.
  always_ff @(posedge clk) begin
    if (rst || state_q != BUSY) tmo_q <= '0;
    else if (!bus_ack)          tmo_q <= tmo_q + 1'b1;
  end

  assign tmo_hit = (state_q == BUSY) && !bus_ack && (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= '0;
      lane_q    <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      rd_data   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      lane_q    <= lane_d;
      bus_req   <= bus_req_d;
      bus_we    <= bus_we_d;
      bus_addr  <= bus_addr_d;
      bus_be    <= bus_be_d;
      bus_wdata <= bus_wdata_d;
      rd_data   <= rd_data_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

  // Next-state and next-output logic; bus fields hold while BUSY.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    lane_d      = lane_q;
    bus_req_d   = bus_req;
    bus_we_d    = bus_we;
    bus_addr_d  = bus_addr;
    bus_be_d    = bus_be;
    bus_wdata_d = bus_wdata;
    rd_data_d   = rd_data;
    done_d      = 1'b0;
    err_d       = 1'b0;
    stall       = 1'b0;
    case (state_q)
      IDLE: begin
        stall = req_any;
        if (req_any) begin
          mode_d = addr_mode;
          lane_d = addr[1:0];
          if (illegal || misaligned) begin
            state_d   = DONE;
            done_d    = 1'b1;
            err_d     = 1'b1;
            rd_data_d = '0;
          end else begin
            state_d     = BUSY;
            bus_req_d   = 1'b1;
            bus_we_d    = mem_wr;
            bus_addr_d  = {addr[DATA_WIDTH-1:2], 2'b00};
            bus_be_d    = st_be;
            bus_wdata_d = st_wdata;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (bus_ack) begin
          state_d   = DONE;
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          done_d    = 1'b1;
          rd_data_d = bus_we ? '0 : fmt_load(mode_q, lane_q, bus_rdata);
        end else if (tmo_hit) begin
          state_d   = DONE;
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          done_d    = 1'b1;
          err_d     = 1'b1;
          rd_data_d = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed vector table, corner sequences, and random traffic against an access-rule model.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst, mem_rd, mem_wr, bus_ack;
  logic [2:0]  addr_mode;
  logic [31:0] addr, wdata, bus_rdata;
  logic        bus_req, bus_we, done, err, stall;
  logic [31:0] bus_addr, bus_wdata, rd_data;
  logic [3:0]  bus_be;

  always #5 clk = ~clk;

  lsu_ctrl #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_wr(mem_wr), .addr_mode(addr_mode),
    .addr(addr), .wdata(wdata), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .rd_data(rd_data), .done(done), .err(err), .stall(stall)
  );

  typedef struct {
    logic        rd, wr;
    logic [2:0]  mode;
    logic [31:0] addr, wdata, rdata;
    int          waits;
    logic        exp_err;
    logic [31:0] exp_rd;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] mode,
                              input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                              input int waits, input logic e, input logic [31:0] erd,
                              input logic [3:0] ebe, input logic [31:0] ewd);
    vec_t v;
    v.rd = rd; v.wr = wr; v.mode = mode; v.addr = a; v.wdata = wd; v.rdata = rdat;
    v.waits = waits; v.exp_err = e; v.exp_rd = erd; v.exp_be = ebe; v.exp_wd = ewd;
    return v;
  endfunction

  // Access-rule model: size in bytes per code, stores are codes 5..7.
  function automatic int m_size(input logic [2:0] mode);
    case (mode)
      3'd0, 3'd3, 3'd5: return 1;
      3'd1, 3'd4, 3'd6: return 2;
      default:          return 4;
    endcase
  endfunction

  function automatic logic m_err(input logic rd, input logic wr, input logic [2:0] mode,
                                 input logic [31:0] a);
    logic st;
    st = (mode >= 3'd5);
    if (rd == wr) return 1'b1;
    if (st != wr) return 1'b1;
    return (a % m_size(mode)) != 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] mode, input logic [31:0] a,
                                         input logic [31:0] w);
    longint val;
    longint bits;
    bits = 8 * m_size(mode);
    val  = (longint'(w) >> ((a % 4) * 8)) & ((64'd1 << bits) - 1);
    if ((mode == 3'd0 || mode == 3'd1) && val >= (64'd1 << (bits - 1)))
      val = val - (64'd1 << bits);
    return 32'(val);
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] mode, input logic [31:0] a);
    if (mode < 3'd5) return 4'hF;
    if (m_size(mode) == 1) return 4'(1 << (a % 4));
    if (m_size(mode) == 2) return 4'(3 << (a % 4));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] mode, input logic [31:0] w);
    if (m_size(mode) == 1) return (w & 32'hFF) * 32'h0101_0101;
    if (m_size(mode) == 2) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  // Entered and left just after a falling edge with the DUT idle.
  task automatic run_txn(input string tag, input vec_t v);
    mem_rd = v.rd; mem_wr = v.wr; addr_mode = v.mode; addr = v.addr; wdata = v.wdata;
    #1 chk({tag, " stall_req"}, 32'(stall), 32'd1);
    @(negedge clk);
    mem_rd = 1'b0; mem_wr = 1'b0; addr = $urandom; wdata = $urandom;
    addr_mode = 3'($urandom_range(0, 7));
    if (v.exp_err) begin
      chk({tag, " err_req"}, 32'(bus_req), 32'd0);
      chk({tag, " err_done"}, 32'(done), 32'd1);
      chk({tag, " err_err"}, 32'(err), 32'd1);
      chk({tag, " err_rd"}, rd_data, 32'd0);
      chk({tag, " err_stall"}, 32'(stall), 32'd0);
    end else begin
      for (int c = 0; c <= v.waits; c++) begin
        chk({tag, " req"}, 32'(bus_req), 32'd1);
        chk({tag, " we"}, 32'(bus_we), 32'(v.wr));
        chk({tag, " addr"}, bus_addr, v.addr & ~32'h3);
        chk({tag, " be"}, 32'(bus_be), 32'(v.exp_be));
        if (v.wr) chk({tag, " wdata"}, bus_wdata, v.exp_wd);
        chk({tag, " busy_done"}, 32'(done), 32'd0);
        chk({tag, " busy_stall"}, 32'(stall), 32'd1);
        if (c == v.waits) begin
          bus_ack = 1'b1; bus_rdata = v.rdata;
        end else begin
          bus_rdata = $urandom;
        end
        @(negedge clk);
      end
      bus_ack = 1'b0; bus_rdata = $urandom;
      chk({tag, " done"}, 32'(done), 32'd1);
      chk({tag, " ok_err"}, 32'(err), 32'd0);
      chk({tag, " rd_data"}, rd_data, v.exp_rd);
      chk({tag, " req_drop"}, 32'(bus_req), 32'd0);
      chk({tag, " done_stall"}, 32'(stall), 32'd0);
    end
    @(negedge clk);
    chk({tag, " done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    rst = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0; addr_mode = 3'd0; addr = '0; wdata = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst bus_req", 32'(bus_req), 32'd0);
    chk("rst bus_we", 32'(bus_we), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst bus_addr", bus_addr, 32'd0);
    chk("rst bus_be", 32'(bus_be), 32'd0);
    chk("rst bus_wdata", bus_wdata, 32'd0);
    chk("rst rd_data", rd_data, 32'd0);
    chk("rst stall", 32'(stall), 32'd0);
    rst = 1'b0;

    // Stray ack while idle.
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    chk("stray done", 32'(done), 32'd0);
    chk("stray req", 32'(bus_req), 32'd0);

    tbl.push_back(mk(1, 0, 3'd0, 32'h1003, 32'h0, 32'h80FF_1234, 2, 0, 32'hFFFF_FF80, 4'hF, 32'h0));
    tbl.push_back(mk(1, 0, 3'd4, 32'h2002, 32'h0, 32'hBEEF_0000, 0, 0, 32'h0000_BEEF, 4'hF, 32'h0));
    tbl.push_back(mk(0, 1, 3'd6, 32'h3002, 32'h1234_ABCD, 32'h5555_5555, 3, 0, 32'h0, 4'hC, 32'hABCD_ABCD));
    tbl.push_back(mk(1, 0, 3'd2, 32'h4001, 32'h0, 32'h0, 0, 1, 32'h0, 4'hF, 32'h0));
    tbl.push_back(mk(1, 0, 3'd2, 32'h5000, 32'h0, 32'hDEAD_BEEF, 1, 0, 32'hDEAD_BEEF, 4'hF, 32'h0));
    tbl.push_back(mk(1, 0, 3'd1, 32'h6000, 32'h0, 32'h1234_8001, 0, 0, 32'hFFFF_8001, 4'hF, 32'h0));
    tbl.push_back(mk(1, 0, 3'd3, 32'h7001, 32'h0, 32'h0000_C300, 1, 0, 32'h0000_00C3, 4'hF, 32'h0));
    tbl.push_back(mk(0, 1, 3'd5, 32'h8002, 32'h0000_00A5, 32'h0, 0, 0, 32'h0, 4'h4, 32'hA5A5_A5A5));
    tbl.push_back(mk(0, 1, 3'd7, 32'h9000, 32'hCAFE_F00D, 32'h0, 2, 0, 32'h0, 4'hF, 32'hCAFE_F00D));
    tbl.push_back(mk(1, 1, 3'd2, 32'hA000, 32'h0, 32'h0, 0, 1, 32'h0, 4'hF, 32'h0));
    tbl.push_back(mk(0, 1, 3'd0, 32'hB000, 32'h0, 32'h0, 0, 1, 32'h0, 4'hF, 32'h0));
    tbl.push_back(mk(1, 0, 3'd7, 32'hC000, 32'h0, 32'h0, 0, 1, 32'h0, 4'hF, 32'h0));
    tbl.push_back(mk(0, 1, 3'd6, 32'hD001, 32'h0, 32'h0, 0, 1, 32'h0, 4'hF, 32'h0));
    tbl.push_back(mk(1, 0, 3'd0, 32'hE000, 32'h0, 32'h1234_567F, 0, 0, 32'h0000_007F, 4'hF, 32'h0));
    foreach (tbl[i]) run_txn($sformatf("vec%0d", i), tbl[i]);

    // Reset while BUSY, followed by a late ack.
    mem_rd = 1'b1; addr_mode = 3'd2; addr = 32'h40;
    @(negedge clk);
    mem_rd = 1'b0;
    chk("rstbusy req_on", 32'(bus_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstbusy req_off", 32'(bus_req), 32'd0);
    chk("rstbusy done", 32'(done), 32'd0);
    chk("rstbusy stall", 32'(stall), 32'd0);
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    chk("rstbusy late_done", 32'(done), 32'd0);
    chk("rstbusy late_req", 32'(bus_req), 32'd0);
    @(negedge clk);
    chk("rstbusy late_done2", 32'(done), 32'd0);

`ifdef LSU_TIMEOUT_EN
    // No ack: request held for four BUSY cycles, then an error completion.
    mem_rd = 1'b1; addr_mode = 3'd2; addr = 32'h80;
    @(negedge clk);
    mem_rd = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("tmo req", 32'(bus_req), 32'd1);
      chk("tmo busy_done", 32'(done), 32'd0);
      @(negedge clk);
    end
    chk("tmo req_drop", 32'(bus_req), 32'd0);
    chk("tmo done", 32'(done), 32'd1);
    chk("tmo err", 32'(err), 32'd1);
    chk("tmo rd", rd_data, 32'd0);
    @(negedge clk);
`endif

    for (int n = 0; n < 300; n++) begin
      vec_t v;
      int   r;
      logic st;
      v.mode = 3'($urandom_range(0, 7));
      st = (v.mode >= 3'd5);
      r = $urandom_range(0, 9);
      if (r == 0)      begin v.rd = 1'b1; v.wr = 1'b1; end
      else if (r == 1) begin v.rd = st;   v.wr = ~st;  end
      else             begin v.rd = ~st;  v.wr = st;   end
      v.addr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (m_size(v.mode) == 4)      v.addr[1:0] = 2'b00;
        else if (m_size(v.mode) == 2) v.addr[0] = 1'b0;
      end
      v.wdata   = $urandom;
      v.rdata   = $urandom;
      v.waits   = $urandom_range(0, 3);
      v.exp_err = m_err(v.rd, v.wr, v.mode, v.addr);
      v.exp_rd  = (v.exp_err || st) ? 32'h0 : m_load(v.mode, v.addr, v.rdata);
      v.exp_be  = m_be(v.mode, v.addr);
      v.exp_wd  = m_wd(v.mode, v.wdata);
      run_txn($sformatf("rnd%0d", n), v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
